mdu_hilo: RTL and testbench

- Multiply/divide unit in the E stage; owns the HI/LO register pair.
- Takes operands from the E-stage forwarded register values and the decoded mult/div op.
- Drives Start and Busy, which the hazard unit uses to stall any HI/LO-class instruction sitting in D.
- HI/LO outputs feed the mfhi/mflo result path into the M stage.

---
 rtl/mdu_hilo_if.sv | 13 +
 rtl/mdu_hilo.sv | 124 ++++++++++++
 tb/tb_mdu_hilo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// E-stage multiply/divide operand, handshake and HI/LO result bundle for mdu_hilo.
interface mdu_hilo_if;
    logic [3:0]  MD_Op;
    logic [31:0] MD_A;
    logic [31:0] MD_B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output MD_Op, MD_A, MD_B, input Start, Busy, HI, LO);
    modport slave  (input MD_Op, MD_A, MD_B, output Start, Busy, HI, LO);
endinterface

// File: rtl/mdu_hilo.sv
// Multicycle multiply/divide unit owning HI/LO; result lands after a fixed busy window.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (ops 7-10) with multiply latency.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_hilo_if.slave  md
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,  OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,  OP_MSUB  = 4'd9, OP_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    logic        is_mul, is_div, start;
    logic [63:0] res, prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{md.MD_A[31]}}, md.MD_A} * {{32{md.MD_B[31]}}, md.MD_B};
    assign prod_u = {32'd0, md.MD_A} * {32'd0, md.MD_B};

    // Signed divide on magnitudes sidesteps the INT_MIN / -1 overflow trap.
    assign a_neg = md.MD_A[31];
    assign b_neg = md.MD_B[31];
    assign a_mag = a_neg ? (~md.MD_A + 32'd1) : md.MD_A;
    assign b_mag = b_neg ? (~md.MD_B + 32'd1) : md.MD_B;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo_s = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        res    = '0;
        case (md.MD_Op)
            OP_MULT:  begin is_mul = 1'b1; res = prod_s; end
            OP_MULTU: begin is_mul = 1'b1; res = prod_u; end
            OP_DIV: begin
                is_div = 1'b1;
                res    = (md.MD_B == '0) ? {md.MD_A, 32'hFFFF_FFFF} : {rem_s, quo_s};
            end
            OP_DIVU: begin
                is_div = 1'b1;
                res    = (md.MD_B == '0) ? {md.MD_A, 32'hFFFF_FFFF}
                                         : {md.MD_A % md.MD_B, md.MD_A / md.MD_B};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; res = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin is_mul = 1'b1; res = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin is_mul = 1'b1; res = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin is_mul = 1'b1; res = {hi_q, lo_q} - prod_u; end
`endif
            default: ;
        endcase
    end

    assign start = (is_mul | is_div) & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_d  = res;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = S_BUSY;
                end else if (md.MD_Op == OP_MTHI) begin
                    hi_d = md.MD_A;
                end else if (md.MD_Op == OP_MTLO) begin
                    lo_d = md.MD_A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.Start = start;
    assign md.Busy  = (state_q == S_BUSY);
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo: arithmetic, latency, mthi/mtlo, async reset, madd option.
module tb_mdu_hilo;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mdu_hilo_if bus ();

    mdu_hilo #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a mult/div-class op for one cycle; returns just after the accept edge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_start);
        @(negedge clk);
        bus.MD_Op = op;
        bus.MD_A  = a;
        bus.MD_B  = b;
        #1 check({tag, "_start"}, bus.Start, exp_start);
        @(posedge clk);
        #1 bus.MD_Op = 4'd0;
    endtask

    task automatic wait_busy(input string tag, input int exp_len);
        int n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_busy_len"}, n, exp_len);
    endtask

    task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.MD_Op = op;
        bus.MD_A  = a;
        #1 check({tag, "_start"}, bus.Start, 1'b0);
        @(posedge clk);
        #1 bus.MD_Op = 4'd0;
        check({tag, "_busy"}, bus.Busy, 1'b0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_hi"}, bus.HI, hi);
        check({tag, "_lo"}, bus.LO, lo);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.MD_Op = 4'd1;
        bus.MD_A  = 32'd5;
        bus.MD_B  = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_follows_op", bus.Start, 1'b1);
        check("rst_busy", bus.Busy, 1'b0);
        check_hilo("rst", 32'h0, 32'h0);
        @(negedge clk);
        bus.MD_Op = 4'd0;
        reset_n   = 1'b1;

        issue("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check("mult_start_drops", bus.Start, 1'b0);
        wait_busy("mult", MULT_CYCLES);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_busy("multu", MULT_CYCLES);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_busy("div", DIV_CYCLES);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Issued in the first idle cycle after Busy falls.
        issue("divu0", 4'd4, 32'd7, 32'd0, 1'b1);
        wait_busy("divu0", DIV_CYCLES);
        check_hilo("divu0", 32'h0000_0007, 32'hFFFF_FFFF);

        issue("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_busy("divovf", DIV_CYCLES);
        check_hilo("divovf", 32'h0, 32'h8000_0000);

        issue("divneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_busy("divneg", DIV_CYCLES);
        check_hilo("divneg", 32'h0000_0001, 32'hFFFF_FFFD);

        move_to("mthi", 4'd5, 32'h0000_1234);
        check_hilo("mthi", 32'h0000_1234, 32'hFFFF_FFFD);
        move_to("mtlo", 4'd6, 32'h0000_ABCD);
        check_hilo("mtlo", 32'h0000_1234, 32'h0000_ABCD);

        issue("divmid", 4'd3, 32'd100, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.MD_Op = 4'd5;
        bus.MD_A  = 32'h0000_5555;
        #1 check("mthi_busy_start", bus.Start, 1'b0);
        @(posedge clk);
        #1 bus.MD_Op = 4'd0;
        check("mthi_busy_hi", bus.HI, 32'h0000_1234);
        wait_busy("divmid", DIV_CYCLES - 2);
        check_hilo("divmid", 32'd2, 32'd14);

        issue("divrst", 4'd4, 32'd50, 32'd3, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", bus.Busy, 1'b0);
        check_hilo("arst", 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", bus.Busy, 1'b0);
        check_hilo("post_rst", 32'h0, 32'h0);

        move_to("mtlo_ff", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        issue("madd", 4'd7, 32'd1, 32'd1, 1'b1);
        wait_busy("madd", MULT_CYCLES);
        check_hilo("madd", 32'h0000_0001, 32'h0000_0000);
        issue("msubu", 4'd10, 32'd2, 32'd3, 1'b1);
        wait_busy("msubu", MULT_CYCLES);
        check_hilo("msubu", 32'h0000_0000, 32'hFFFF_FFFA);
`else
        issue("madd_off", 4'd7, 32'd1, 32'd1, 1'b0);
        check("madd_off_busy", bus.Busy, 1'b0);
        repeat (MULT_CYCLES + 1) @(posedge clk);
        #1;
        check_hilo("madd_off", 32'h0, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
